// File: rtl/coherence_bus_ctrl_n.sv
// N-processor coherence/memory controller: round-robin arbitration of
// instruction and data requests onto one RAM port, with an MSI snoop
// sequence (broadcast, invalidate, cache-to-cache transfer plus memory update).
module coherence_bus_ctrl_n #(
  parameter int CPUS     = 2,
  parameter int BLKWORDS = 2,
  parameter int WORD_W   = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS*WORD_W-1:0]   iaddr,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*WORD_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  input  logic [CPUS-1:0]          ccwrite,
  input  logic [CPUS-1:0]          cctrans,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic [CPUS-1:0]          ccwait,
  output logic [CPUS-1:0]          ccinv,
  output logic [CPUS*WORD_W-1:0]   ccsnoopaddr,
  input  logic [WORD_W-1:0]        ramload,
  input  logic [1:0]               ramstate,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  output logic                     ramREN,
  output logic                     ramWEN
);

  localparam int IDX_W  = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int BEAT_W = $clog2(BLKWORDS + 1);
  localparam logic [1:0] RS_ACCESS = 2'd2;

  typedef enum logic [2:0] {IDLE, IFETCH, DWB, SNOOP, C2C, RAMRD} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   g_q, g_d;        // granted requester
  logic [IDX_W-1:0]   o_q, o_d;        // dirty owner supplying the block
  logic [IDX_W-1:0]   iptr_q, iptr_d;
  logic [IDX_W-1:0]   dptr_q, dptr_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               snp_q, snp_d;    // snoop lines stay up through a snooped read

  logic               req_g;
  logic               acc;
  logic               last;
  logic [CPUS-1:0]    dreq;
  logic [CPUS-1:0]    gmask;
  logic [CPUS-1:0]    dirty;

  // First requester at or after ptr, wrapping around the CPU ring.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [CPUS-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] w;
    logic             found;
    int               idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < CPUS; k++) begin
      idx = (int'(ptr) + k) % CPUS;
      if (!found && req[idx]) begin
        w     = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
    return IDX_W'((int'(i) + 1) % CPUS);
  endfunction

  // State and arbitration registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      g_q     <= '0;
      o_q     <= '0;
      iptr_q  <= '0;
      dptr_q  <= '0;
      beat_q  <= '0;
      snp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      o_q     <= o_d;
      iptr_q  <= iptr_d;
      dptr_q  <= dptr_d;
      beat_q  <= beat_d;
      snp_q   <= snp_d;
    end
  end

  // Next state: arbitration in IDLE, beat counting and abort elsewhere.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    o_d     = o_q;
    iptr_d  = iptr_q;
    dptr_d  = dptr_q;
    beat_d  = beat_q;
    snp_d   = snp_q;
    gmask   = '0;
    gmask[g_q] = 1'b1;
    dreq    = (dWEN & ~cctrans) | dREN;
    dirty   = ccwrite & ~gmask;
    case (state_q)
      IFETCH:                req_g = iREN[g_q];
      DWB:                   req_g = dWEN[g_q];
      SNOOP, C2C, RAMRD:     req_g = dREN[g_q];
      default:               req_g = 1'b0;
    endcase
    // ERROR and BUSY both stall; only ACCESS with a live request is a beat.
    acc  = (ramstate == RS_ACCESS) && req_g;
    last = (beat_q == BEAT_W'(BLKWORDS - 1));
    case (state_q)
      IDLE: begin
        beat_d = '0;
        snp_d  = 1'b0;
        if (|dreq) begin
          g_d = rr_pick(dreq, dptr_q);
          if (dWEN[g_d] && !cctrans[g_d]) state_d = DWB;
          else if (cctrans[g_d])          state_d = SNOOP;
          else                            state_d = RAMRD;
        end else if (|iREN) begin
          g_d     = rr_pick(iREN, iptr_q);
          state_d = IFETCH;
        end
      end
      IFETCH: begin
        if (!req_g || acc) begin
          state_d = IDLE;
          iptr_d  = nxt(g_q);
        end
      end
      SNOOP: begin
        if (!req_g) begin
          state_d = IDLE;
          dptr_d  = nxt(g_q);
        end else if (|dirty) begin
          o_d     = rr_pick(dirty, dptr_q);
          state_d = C2C;
        end else begin
          state_d = RAMRD;
          snp_d   = 1'b1;
        end
      end
      DWB, C2C, RAMRD: begin
        if (!req_g || (acc && last)) begin
          state_d = IDLE;
          beat_d  = '0;
          dptr_d  = nxt(g_q);
        end else if (acc) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: stalls high and data zero unless the granted CPU is served.
  always_comb begin
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramaddr     = '0;
    ramstore    = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    case (state_q)
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[g_q*WORD_W +: WORD_W];
        if (acc) begin
          iwait[g_q]                 = 1'b0;
          iload[g_q*WORD_W +: WORD_W] = ramload;
        end
      end
      DWB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[g_q*WORD_W +: WORD_W];
        ramstore = dstore[g_q*WORD_W +: WORD_W];
        if (acc) dwait[g_q] = 1'b0;
      end
      SNOOP, RAMRD: begin
        if (state_q == RAMRD) begin
          ramREN  = 1'b1;
          ramaddr = daddr[g_q*WORD_W +: WORD_W];
          if (acc) begin
            dwait[g_q]                 = 1'b0;
            dload[g_q*WORD_W +: WORD_W] = ramload;
          end
        end
        if ((CPUS > 1) && (state_q == SNOOP || snp_q)) begin
          for (int j = 0; j < CPUS; j++) begin
            if (j != int'(g_q)) begin
              ccwait[j]                      = 1'b1;
              ccinv[j]                       = ccwrite[g_q];
              ccsnoopaddr[j*WORD_W +: WORD_W] = daddr[g_q*WORD_W +: WORD_W];
            end
          end
        end
      end
      C2C: begin
        if (CPUS > 1) begin
          ccwait[o_q]                      = 1'b1;
          ccinv[o_q]                       = ccwrite[g_q];
          ccsnoopaddr[o_q*WORD_W +: WORD_W] = daddr[g_q*WORD_W +: WORD_W];
        end
        // Owner's dirty word goes to the requester and to memory at once.
        ramWEN                      = 1'b1;
        ramaddr                     = daddr[o_q*WORD_W +: WORD_W];
        ramstore                    = dstore[o_q*WORD_W +: WORD_W];
        dload[g_q*WORD_W +: WORD_W] = dstore[o_q*WORD_W +: WORD_W];
        if (acc) begin
          dwait[g_q] = 1'b0;
          dwait[o_q] = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl_n.sv
// Directed bench for coherence_bus_ctrl_n: a 2-CPU instance driven from a
// per-cycle vector table, and a 4-CPU instance for pointer-wrap and snoop fan-out.
module tb_coherence_bus_ctrl_n;

  logic        CLK;
  logic        RST;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  // 2-CPU instance
  logic [1:0]  iren2, dren2, dwen2, cct2, ccw2;
  logic [63:0] iaddr2, daddr2, dstore2;
  logic [1:0]  iwait2, dwait2, ccwait2, ccinv2;
  logic [63:0] iload2, dload2, snp2;
  logic [31:0] ramaddr2, ramstore2;
  logic        ren2, wen2;

  // 4-CPU instance
  logic [3:0]   iren4, dren4, dwen4, cct4, ccw4;
  logic [127:0] iaddr4, daddr4, dstore4;
  logic [3:0]   iwait4, dwait4, ccwait4, ccinv4;
  logic [127:0] iload4, dload4, snp4;
  logic [31:0]  ramaddr4, ramstore4;
  logic         ren4, wen4;

  int total;
  int bad;

  coherence_bus_ctrl_n #(.CPUS(2), .BLKWORDS(2), .WORD_W(32)) dut2 (
    .CLK(CLK), .RST(RST), .iREN(iren2), .iaddr(iaddr2), .dREN(dren2), .dWEN(dwen2),
    .daddr(daddr2), .dstore(dstore2), .ccwrite(ccw2), .cctrans(cct2),
    .iwait(iwait2), .dwait(dwait2), .iload(iload2), .dload(dload2),
    .ccwait(ccwait2), .ccinv(ccinv2), .ccsnoopaddr(snp2),
    .ramload(ramload), .ramstate(ramstate), .ramaddr(ramaddr2), .ramstore(ramstore2),
    .ramREN(ren2), .ramWEN(wen2));

  coherence_bus_ctrl_n #(.CPUS(4), .BLKWORDS(2), .WORD_W(32)) dut4 (
    .CLK(CLK), .RST(RST), .iREN(iren4), .iaddr(iaddr4), .dREN(dren4), .dWEN(dwen4),
    .daddr(daddr4), .dstore(dstore4), .ccwrite(ccw4), .cctrans(cct4),
    .iwait(iwait4), .dwait(dwait4), .iload(iload4), .dload(dload4),
    .ccwait(ccwait4), .ccinv(ccinv4), .ccsnoopaddr(snp4),
    .ramload(ramload), .ramstate(ramstate), .ramaddr(ramaddr4), .ramstore(ramstore4),
    .ramREN(ren4), .ramWEN(wen4));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    string       nm;
    logic [1:0]  iren, dren, dwen, cct, ccw, rs;
    logic [31:0] rl, da0, da1, ds1;
    logic [1:0]  e_iw, e_dw, e_cw, e_ci;
    logic        e_ren, e_wen;
    logic [31:0] e_ra, e_rst, e_il0, e_il1, e_dl0, e_dl1, e_sa0, e_sa1;
  } vec_t;

  localparam int NV = 31;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //            name   iren   dren   dwen   cct    ccw    rs     rl            da0     da1     ds1           iw     dw     cw     ci     ren   wen   ra      rst           il0           il1           dl0           dl1      sa0     sa1
    // Two instruction fetchers, CPU0 first, then CPU1; aborts still advance iptr
    tbl[0]  = '{"A1",  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'd1, 32'h0,        32'h0,  32'h0,  32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    tbl[1]  = '{"A2",  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'd1, 32'h1111,     32'h0,  32'h0,  32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    tbl[2]  = '{"A3",  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'd2, 32'hAAAA0100, 32'h0,  32'h0,  32'h0,        2'b10, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0,        32'hAAAA0100, 32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    tbl[3]  = '{"A4",  2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,        32'h0,  32'h0,  32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    tbl[4]  = '{"A5",  2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'd2, 32'hBBBB0200, 32'h0,  32'h0,  32'h0,        2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h200, 32'h0,        32'h0,        32'hBBBB0200, 32'h0,        32'h0,   32'h0,  32'h0};
    tbl[5]  = '{"A6",  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,        32'h0,  32'h0,  32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    tbl[6]  = '{"A7",  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'd1, 32'h0,        32'h0,  32'h0,  32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    tbl[7]  = '{"A8",  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'd2, 32'h77,       32'h0,  32'h0,  32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    tbl[8]  = '{"A9",  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,        32'h0,  32'h0,  32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    tbl[9]  = '{"A10", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'd2, 32'h77,       32'h0,  32'h0,  32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h200, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    tbl[10] = '{"A11", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,        32'h0,  32'h0,  32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    // CPU1 shared read with no dirty owner: SNOOP then 2-beat RAMRD, ERROR is no beat
    tbl[11] = '{"B1",  2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'd0, 32'h0,        32'h0,  32'h40, 32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    tbl[12] = '{"B2",  2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'd1, 32'h0,        32'h0,  32'h40, 32'h0,        2'b11, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h40, 32'h0};
    tbl[13] = '{"B3",  2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'd1, 32'h0,        32'h0,  32'h40, 32'h0,        2'b11, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 32'h40,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h40, 32'h0};
    tbl[14] = '{"B4",  2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'd2, 32'hD0,       32'h0,  32'h40, 32'h0,        2'b11, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 32'h40,  32'h0,        32'h0,        32'h0,        32'h0,        32'hD0,  32'h40, 32'h0};
    tbl[15] = '{"B5",  2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'd3, 32'hEE,       32'h0,  32'h40, 32'h0,        2'b11, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 32'h40,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h40, 32'h0};
    tbl[16] = '{"B6",  2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'd2, 32'hD1,       32'h0,  32'h40, 32'h0,        2'b11, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 32'h40,  32'h0,        32'h0,        32'h0,        32'h0,        32'hD1,  32'h40, 32'h0};
    tbl[17] = '{"B7",  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,        32'h0,  32'h40, 32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    // CPU0 BusRdX, CPU1 dirty owner: invalidate and cache-to-cache with memory update
    tbl[18] = '{"C1",  2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'd0, 32'h0,        32'h80, 32'h80, 32'hDEADBEEF, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    tbl[19] = '{"C2",  2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 2'd1, 32'h0,        32'h80, 32'h80, 32'hDEADBEEF, 2'b11, 2'b11, 2'b10, 2'b10, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h80};
    tbl[20] = '{"C3",  2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 2'd1, 32'h0,        32'h80, 32'h80, 32'hDEADBEEF, 2'b11, 2'b11, 2'b10, 2'b10, 1'b0, 1'b1, 32'h80,  32'hDEADBEEF, 32'h0,        32'h0,        32'hDEADBEEF, 32'h0,   32'h0,  32'h80};
    tbl[21] = '{"C4",  2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 2'd2, 32'h0,        32'h80, 32'h80, 32'hDEADBEEF, 2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 32'h80,  32'hDEADBEEF, 32'h0,        32'h0,        32'hDEADBEEF, 32'h0,   32'h0,  32'h80};
    tbl[22] = '{"C5",  2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 2'd2, 32'h0,        32'h80, 32'h80, 32'hCAFEF00D, 2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 32'h80,  32'hCAFEF00D, 32'h0,        32'h0,        32'hCAFEF00D, 32'h0,   32'h0,  32'h80};
    tbl[23] = '{"C6",  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,        32'h0,  32'h0,  32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    // iREN0 against dWEN1 writeback: writeback first (2 beats), then the fetch
    tbl[24] = '{"E1",  2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'd0, 32'h0,        32'h0,  32'h300, 32'h55,      2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    tbl[25] = '{"E2",  2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'd2, 32'h0,        32'h0,  32'h300, 32'h55,      2'b11, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 32'h300, 32'h55,       32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    tbl[26] = '{"E3",  2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'd1, 32'h0,        32'h0,  32'h300, 32'h55,      2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 32'h300, 32'h55,       32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    tbl[27] = '{"E4",  2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'd2, 32'h0,        32'h0,  32'h300, 32'h66,      2'b11, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 32'h300, 32'h66,       32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    tbl[28] = '{"E5",  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,        32'h0,  32'h0,  32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    tbl[29] = '{"E6",  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'd2, 32'h1234,     32'h0,  32'h0,  32'h0,        2'b10, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0,        32'h1234,     32'h0,        32'h0,        32'h0,   32'h0,  32'h0};
    tbl[30] = '{"E7",  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0,        32'h0,  32'h0,  32'h0,        2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,   32'h0,  32'h0};

    // Reset state, with requests pending to show nothing is granted
    RST      = 1'b1;
    ramload  = 32'h0;
    ramstate = 2'd2;
    iren2 = 2'b11; dren2 = '0; dwen2 = '0; cct2 = '0; ccw2 = '0;
    iaddr2  = {32'h200, 32'h100};
    daddr2  = '0;
    dstore2 = '0;
    iren4 = 4'b1111; dren4 = '0; dwen4 = '0; cct4 = '0; ccw4 = '0;
    iaddr4  = '0;
    daddr4  = {32'h1030, 32'h1020, 32'h1010, 32'h1000};
    dstore4 = '0;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("rst.iwait2",  128'(iwait2),   128'(2'b11));
    chk("rst.dwait2",  128'(dwait2),   128'(2'b11));
    chk("rst.ccwait2", 128'(ccwait2),  128'(2'b00));
    chk("rst.ccinv2",  128'(ccinv2),   128'(2'b00));
    chk("rst.ren2",    128'(ren2),     128'(1'b0));
    chk("rst.wen2",    128'(wen2),     128'(1'b0));
    chk("rst.raddr2",  128'(ramaddr2), 128'(32'h0));
    chk("rst.iload2",  128'(iload2),   128'(64'h0));
    chk("rst.snp2",    128'(snp2),     128'(64'h0));
    chk("rst.iwait4",  128'(iwait4),   128'(4'hF));
    chk("rst.ren4",    128'(ren4),     128'(1'b0));
    iren2 = '0;
    iren4 = '0;
    RST   = 1'b0;

    // Table-driven vectors on the 2-CPU instance
    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      iren2    = tbl[i].iren;
      dren2    = tbl[i].dren;
      dwen2    = tbl[i].dwen;
      cct2     = tbl[i].cct;
      ccw2     = tbl[i].ccw;
      ramstate = tbl[i].rs;
      ramload  = tbl[i].rl;
      daddr2   = {tbl[i].da1, tbl[i].da0};
      dstore2  = {tbl[i].ds1, 32'h0};
      #1;
      chk({tbl[i].nm, ".iwait"},  128'(iwait2),          128'(tbl[i].e_iw));
      chk({tbl[i].nm, ".dwait"},  128'(dwait2),          128'(tbl[i].e_dw));
      chk({tbl[i].nm, ".ccwait"}, 128'(ccwait2),         128'(tbl[i].e_cw));
      chk({tbl[i].nm, ".ccinv"},  128'(ccinv2),          128'(tbl[i].e_ci));
      chk({tbl[i].nm, ".ramREN"}, 128'(ren2),            128'(tbl[i].e_ren));
      chk({tbl[i].nm, ".ramWEN"}, 128'(wen2),            128'(tbl[i].e_wen));
      chk({tbl[i].nm, ".ramaddr"},  128'(ramaddr2),      128'(tbl[i].e_ra));
      chk({tbl[i].nm, ".ramstore"}, 128'(ramstore2),     128'(tbl[i].e_rst));
      chk({tbl[i].nm, ".iload"},  128'(iload2), 128'({tbl[i].e_il1, tbl[i].e_il0}));
      chk({tbl[i].nm, ".dload"},  128'(dload2), 128'({tbl[i].e_dl1, tbl[i].e_dl0}));
      chk({tbl[i].nm, ".snpaddr"}, 128'(snp2),  128'({tbl[i].e_sa1, tbl[i].e_sa0}));
    end

    // Reset during a RAMRD after one beat; the read restarts from beat 0
    @(negedge CLK); dren2 = 2'b01; cct2 = '0; ccw2 = '0; daddr2 = {32'h0, 32'h500}; ramstate = 2'd0; #1;
    chk("R.idle.ren", 128'(ren2), 128'(1'b0));
    @(negedge CLK); ramstate = 2'd2; ramload = 32'h11; #1;
    chk("R.beat1.dwait", 128'(dwait2), 128'(2'b10));
    chk("R.beat1.ren",   128'(ren2),   128'(1'b1));
    @(negedge CLK); RST = 1'b1; #1;
    chk("R.rst.dwait", 128'(dwait2),   128'(2'b11));
    chk("R.rst.ren",   128'(ren2),     128'(1'b0));
    chk("R.rst.raddr", 128'(ramaddr2), 128'(32'h0));
    @(negedge CLK); RST = 1'b0; ramstate = 2'd0; #1;
    chk("R.post.ren", 128'(ren2), 128'(1'b0));
    @(negedge CLK); ramstate = 2'd2; ramload = 32'h21; #1;
    chk("R.b0.raddr", 128'(ramaddr2), 128'(32'h500));
    chk("R.b0.dwait", 128'(dwait2),   128'(2'b10));
    chk("R.b0.dload", 128'(dload2),   128'({32'h0, 32'h21}));
    @(negedge CLK); ramload = 32'h22; #1;
    chk("R.b1.ren",   128'(ren2),   128'(1'b1));
    chk("R.b1.dload", 128'(dload2), 128'({32'h0, 32'h22}));
    @(negedge CLK); dren2 = '0; ramstate = 2'd0; #1;
    chk("R.done.ren", 128'(ren2), 128'(1'b0));

    // 4-CPU: move dptr to 2 via CPU1, then CPU3 beats CPU1, then dptr wraps to 0
    @(negedge CLK); dren4 = 4'b0010; ramstate = 2'd0; #1;
    chk("Q.idle.ren", 128'(ren4), 128'(1'b0));
    @(negedge CLK); ramstate = 2'd2; #1;
    chk("Q.g1a.raddr", 128'(ramaddr4), 128'(32'h1010));
    chk("Q.g1a.dwait", 128'(dwait4),   128'(4'b1101));
    @(negedge CLK); dren4 = 4'b1010; #1;
    chk("Q.g1b.raddr", 128'(ramaddr4), 128'(32'h1010));
    @(negedge CLK); ramstate = 2'd0; #1;
    chk("Q.idle2.ren", 128'(ren4), 128'(1'b0));
    @(negedge CLK); ramstate = 2'd2; #1;
    chk("Q.g3a.raddr", 128'(ramaddr4), 128'(32'h1030));
    chk("Q.g3a.dwait", 128'(dwait4),   128'(4'b0111));
    @(negedge CLK); #1;
    chk("Q.g3b.raddr", 128'(ramaddr4), 128'(32'h1030));
    @(negedge CLK); ramstate = 2'd0; #1;
    chk("Q.idle3.ren", 128'(ren4), 128'(1'b0));
    @(negedge CLK); ramstate = 2'd2; #1;
    chk("Q.g1c.raddr", 128'(ramaddr4), 128'(32'h1010));
    chk("Q.g1c.dwait", 128'(dwait4),   128'(4'b1101));
    @(negedge CLK); dren4 = 4'b0010; #1;
    chk("Q.g1d.raddr", 128'(ramaddr4), 128'(32'h1010));

    // 4-CPU snoop broadcast to every CPU but the requester
    @(negedge CLK); dren4 = 4'b0100; cct4 = 4'b0100; ccw4 = 4'b0000; ramstate = 2'd0; #1;
    chk("S.idle.ccwait", 128'(ccwait4), 128'(4'b0000));
    @(negedge CLK); ramstate = 2'd1; #1;
    chk("S.snoop.ccwait", 128'(ccwait4), 128'(4'b1011));
    chk("S.snoop.ccinv",  128'(ccinv4),  128'(4'b0000));
    chk("S.snoop.addr",   128'(snp4),    {32'h1020, 32'h0, 32'h1020, 32'h1020});
    @(negedge CLK); dren4 = 4'b0000; cct4 = 4'b0000; #1;
    chk("S.rd.ccwait", 128'(ccwait4), 128'(4'b1011));
    chk("S.rd.ren",    128'(ren4),    128'(1'b1));
    @(negedge CLK); #1;
    chk("S.end.ccwait", 128'(ccwait4), 128'(4'b0000));
    chk("S.end.ren",    128'(ren4),    128'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
